// File: rtl/apb_master_bridge.sv
// APB4 initiator for the timer register block: one valid/ready command becomes one APB
// transfer, and its read data and error status come back on a valid/ready response channel.
module apb_master_bridge #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [3:0]        pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // state    | meaning
    // S_IDLE   | cmd_ready high, waiting for a command
    // S_SETUP  | command latched, psel rises on the next edge
    // S_ACCESS | psel high; first cycle raises penable, then pready/timeout is sampled
    // S_RESP   | rsp_valid high, waiting for rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    localparam logic        TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state, state_nxt;
    logic [15:0]       wait_cnt, wait_cnt_nxt;
    logic              psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;
    logic [3:0]        pstrb_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;

    // cmd_ready and busy are pure decodes of the state register.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= 4'h0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            psel        <= psel_nxt;
            penable     <= penable_nxt;
            pwrite      <= pwrite_nxt;
            paddr       <= paddr_nxt;
            pwdata      <= pwdata_nxt;
            pstrb       <= pstrb_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        psel_nxt        = psel;
        penable_nxt     = penable;
        pwrite_nxt      = pwrite;
        paddr_nxt       = paddr;
        pwdata_nxt      = pwdata;
        pstrb_nxt       = pstrb;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    paddr_nxt    = cmd_addr & ~ADDR_W'(3);
                    pwrite_nxt   = cmd_write;
                    pwdata_nxt   = cmd_wdata;
                    pstrb_nxt    = cmd_write ? cmd_strb : 4'h0;
                    wait_cnt_nxt = '0;
                    state_nxt    = S_SETUP;
                end
            end
            S_SETUP: begin
                psel_nxt    = 1'b1;
                penable_nxt = 1'b0;
                state_nxt   = S_ACCESS;
            end
            S_ACCESS: begin
                if (!penable) begin
                    penable_nxt = 1'b1;
                end else if (pready) begin
                    // pready takes priority over a timeout hitting in the same cycle
                    rsp_rdata_nxt   = pwrite ? '0 : prdata;
                    rsp_err_nxt     = pslverr;
                    rsp_timeout_nxt = 1'b0;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = S_RESP;
                end else if (TO_EN && (wait_cnt == TO_LAST)) begin
                    rsp_rdata_nxt   = '0;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = S_RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
